// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY, RESP)
//   owner_e     : which requester owns the current transaction
//   DEF_*       : default parameter values
//   cnt_width() : bits needed to hold a counter value 0..max_val
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int DEF_ADDRESS_SIZE = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 16;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch requester (f_*), the load/store
// requester (d_*), the shared response (rdata/err) and the memory-side
// handshake (mem_*).
//   modport slave  : the arbiter's view (requests and mem_ack/mem_rdata in)
//   modport master : the environment's view (requesters plus memory)
interface mem_arbiter_if #(
  parameter int ADDRESS_SIZE = 32
);
  logic                    f_req;
  logic [ADDRESS_SIZE-1:0] f_addr;
  logic                    f_gnt;
  logic                    f_done;

  logic                    d_req;
  logic [ADDRESS_SIZE-1:0] d_addr;
  logic                    d_we;
  logic [ADDRESS_SIZE-1:0] d_wdata;
  logic                    d_gnt;
  logic                    d_done;

  logic [ADDRESS_SIZE-1:0] rdata;
  logic                    err;

  logic                    mem_req;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] mem_wdata;
  logic                    mem_ack;
  logic [ADDRESS_SIZE-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_we, d_wdata, mem_ack, mem_rdata,
    output f_gnt, f_done, d_gnt, d_done, rdata, err,
           mem_req, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, d_we, d_wdata, mem_ack, mem_rdata,
    input  f_gnt, f_done, d_gnt, d_done, rdata, err,
           mem_req, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: saturating up-counter with terminal flag.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (highest priority)
//   load     : load load_val (next priority)
//   en       : count up by one; holds once TERMINAL is reached
//   term     : count equals TERMINAL
module mem_arb_timer #(
  parameter int WIDTH    = 5,
  parameter int TERMINAL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             term
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_q, count_d;

  assign term = (count_q == TERM_V);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && !term) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (F) and
// load/store (D). One transaction at a time: IDLE picks a winner, BUSY
// holds mem_req until mem_ack or watchdog abort, RESP pulses done.
// D has priority unless F has waited through STARVE_LIMIT D grants.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_arbiter_if.slave (requesters, response, memory port)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int WD_W = cnt_width(TIMEOUT);
  localparam int SK_W = cnt_width(STARVE_LIMIT);

  arb_state_e              state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic                    f_gnt_q, f_gnt_d;
  logic                    d_gnt_q, d_gnt_d;
  logic                    f_done_q, f_done_d;
  logic                    d_done_q, d_done_d;
  logic [ADDRESS_SIZE-1:0] rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDRESS_SIZE-1:0] mem_wdata_q, mem_wdata_d;

  logic wd_load, wd_clr, wd_en, wd_term;
  logic streak_inc, streak_clr, streak_full;

  assign wd_en = (state_q == BUSY);

  // The watchdog is loaded with 1 at grant so that its value equals the
  // number of cycles mem_req has been high; term means TIMEOUT cycles elapsed.
  mem_arb_timer #(
    .WIDTH    (WD_W),
    .TERMINAL (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (reset),
    .clr      (wd_clr),
    .en       (wd_en),
    .load     (wd_load),
    .load_val (WD_W'(1)),
    .term     (wd_term)
  );

  // Streak of D grants taken while F was waiting; saturates at STARVE_LIMIT.
  mem_arb_timer #(
    .WIDTH    (SK_W),
    .TERMINAL (STARVE_LIMIT)
  ) u_streak (
    .clk      (clk),
    .rst      (reset),
    .clr      (streak_clr),
    .en       (streak_inc),
    .load     (1'b0),
    .load_val ('0),
    .term     (streak_full)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    f_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    f_done_d    = 1'b0;
    d_done_d    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    wd_load     = 1'b0;
    wd_clr      = 1'b0;
    streak_inc  = 1'b0;
    streak_clr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.d_req && !(bus.f_req && streak_full)) begin
          owner_d     = OWN_D;
          mem_addr_d  = bus.d_addr;
          mem_we_d    = bus.d_we;
          mem_wdata_d = bus.d_wdata;
          d_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          wd_load     = 1'b1;
          state_d     = BUSY;
          // Only grants that make F wait count toward the streak.
          streak_inc  = bus.f_req;
          streak_clr  = !bus.f_req;
        end else if (bus.f_req) begin
          owner_d     = OWN_F;
          mem_addr_d  = bus.f_addr;
          mem_we_d    = 1'b0;
          mem_wdata_d = '0;
          f_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          wd_load     = 1'b1;
          state_d     = BUSY;
          streak_clr  = 1'b1;
        end
      end

      BUSY: begin
        // A real ack in the last allowed cycle wins over the abort.
        if (bus.mem_ack) begin
          rdata_d   = bus.mem_rdata;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
          wd_clr    = 1'b1;
          f_done_d  = (owner_q == OWN_F);
          d_done_d  = (owner_q == OWN_D);
          state_d   = RESP;
        end else if (wd_term) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          wd_clr    = 1'b1;
          f_done_d  = (owner_q == OWN_F);
          d_done_d  = (owner_q == OWN_D);
          state_d   = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_F;
      f_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      f_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      f_gnt_q     <= f_gnt_d;
      d_gnt_q     <= d_gnt_d;
      f_done_q    <= f_done_d;
      d_done_q    <= d_done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.f_gnt     = f_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.f_done    = f_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
